serial_frame_deserializer: RTL



---
 rtl/serial_frame_deserializer.sv | 83 ++++++++
 1 files changed

// File: rtl/serial_frame_deserializer.sv
// Start/stop framed serial-to-parallel receiver, one bit per clk, LSB first.
// Emits each good (N+1)-bit word with a one-cycle valid; a bad stop bit gives frame_err.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle; a 0 on in is taken as a start bit
// DATA      | shifting in N+1 data bits, LSB first
// STOP      | sampling the stop bit; 1 publishes the word, 0 is a framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module serial_frame_deserializer #(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [N:0] out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(N + 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N:0]    shreg;
  logic [CW-1:0] cnt;
  logic          load_word;
  logic          err_word;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!in) state_nxt = DATA;
      DATA:      if (cnt == CW'(N)) state_nxt = STOP;
      STOP:      state_nxt = in ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (in) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    load_word = (state == STOP) && in;
    err_word  = (state == STOP) && !in;
  end

  // Strobes are registered so they line up with the cycle out changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      shreg     <= '0;
      cnt       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= load_word;
      frame_err <= err_word;
      if (load_word) out <= shreg;
      case (state)
        IDLE: cnt <= '0;
        DATA: begin
          shreg <= {in, shreg[N:1]};
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
